stack_prog_loader: RTL and testbench

Upstream loader and run controller for the 8-bit stack-machine core. It receives a framed program over a byte-wide valid/ready stream and verifies a checksum. It writes 12-bit instructions into the core's code memory and pads unused words with HALT. It then releases the core from reset and supervises execution until HALT, a fault, or a timeout.

---
 rtl/stack_pkg.sv | 50 +++++
 rtl/stack_prog_loader.sv | 205 ++++++++++++++++++++
 tb/tb_stack_prog_loader.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg: shared opcodes, framing constants and enums for the program loader.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package stack_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 12;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  localparam logic [3:0] OP_CONST = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_OUT   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hB;

  localparam logic [11:0] HALT_INSTR = {8'h00, OP_HALT};

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_FORMAT = 2'd1,
    ERR_CSUM   = 2'd2,
    ERR_CORE   = 2'd3
  } err_e;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_LEN  = 4'd1,
    ST_LO   = 4'd2,
    ST_HI   = 4'd3,
    ST_CSUM = 4'd4,
    ST_FILL = 4'd5,
    ST_RUN  = 4'd6,
    ST_DONE = 4'd7,
    ST_ERR  = 4'd8
  } state_e;

endpackage

`default_nettype wire

// File: rtl/stack_prog_loader.sv
// -----------------------------------------------------------------------------
// stack_prog_loader: framed program loader, HALT padder and core run supervisor.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module stack_prog_loader
  import stack_pkg::*;
#(
  parameter int          ADDR_W  = DEF_ADDR_W,
  parameter int          INSTR_W = DEF_INSTR_W,
  parameter logic [15:0] MAX_RUN = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_rst_n,
  input  logic               core_guard,
  input  logic               core_value,
  output logic               done,
  output logic [1:0]         err_code,
  output logic [15:0]        run_cycles
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  n_q, n_d;
  logic [ADDR_W-1:0]  wcnt_q, wcnt_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         lo_q, lo_d;
  logic               in_ready_q, in_ready_d;
  logic               imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [INSTR_W-1:0] imem_wdata_q, imem_wdata_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               done_q, done_d;
  err_e               err_q, err_d;
  logic [15:0]        run_cycles_q, run_cycles_d;

  logic               xfer;
  logic               n_bad;
  logic [ADDR_W-1:0]  wcnt_inc;
  logic [15:0]        run_inc;

  assign xfer     = in_valid & in_ready_q;
  // Zero length, or a length that does not fit the code memory, is malformed.
  assign n_bad    = (in_data == 8'h00) || ((16'(in_data) >> ADDR_W) != 16'd0);
  assign wcnt_inc = wcnt_q + ADDR_W'(1);
  assign run_inc  = (run_cycles_q == 16'hFFFF) ? run_cycles_q : run_cycles_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    wcnt_d       = wcnt_q;
    csum_d       = csum_q;
    lo_d         = lo_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    done_d       = done_q;
    err_d        = err_q;
    run_cycles_d = run_cycles_q;

    case (state_q)
      ST_IDLE: begin
        done_d       = 1'b0;
        err_d        = ERR_NONE;
        run_cycles_d = '0;
        wcnt_d       = '0;
        if (xfer && in_data == FRAME_HDR) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (xfer) begin
          if (n_bad) begin
            state_d = ST_ERR;
            err_d   = ERR_FORMAT;
          end else begin
            n_d     = ADDR_W'(in_data);
            csum_d  = in_data;
            state_d = ST_LO;
          end
        end
      end
      ST_LO: begin
        if (xfer) begin
          lo_d    = in_data;
          csum_d  = csum_q + in_data;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (xfer) begin
          if (in_data[7:4] != 4'h0) begin
            state_d = ST_ERR;
            err_d   = ERR_FORMAT;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = wcnt_q;
            imem_wdata_d = INSTR_W'({in_data[3:0], lo_q});
            csum_d       = csum_q + in_data;
            wcnt_d       = wcnt_inc;
            state_d      = (wcnt_inc == n_q) ? ST_CSUM : ST_LO;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          if (in_data != csum_q) begin
            state_d = ST_ERR;
            err_d   = ERR_CSUM;
          end else begin
            // First pad write issues together with the transition into FILL.
            imem_we_d    = 1'b1;
            imem_addr_d  = n_q;
            imem_wdata_d = INSTR_W'(HALT_INSTR);
            wcnt_d       = n_q;
            state_d      = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        // wcnt_q holds the address currently on the write port.
        if (wcnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          imem_we_d    = 1'b1;
          imem_addr_d  = wcnt_inc;
          imem_wdata_d = INSTR_W'(HALT_INSTR);
          wcnt_d       = wcnt_inc;
        end
      end
      ST_RUN: begin
        run_cycles_d = run_inc;
        if (core_guard && core_value) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (!core_guard || run_inc == MAX_RUN) begin
          state_d = ST_ERR;
          err_d   = ERR_CORE;
        end
      end
      ST_DONE, ST_ERR: begin
        if (xfer && in_data == FRAME_HDR) begin
          done_d       = 1'b0;
          err_d        = ERR_NONE;
          run_cycles_d = '0;
          wcnt_d       = '0;
          state_d      = ST_LEN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d   = (state_d != ST_FILL) && (state_d != ST_RUN);
    core_rst_n_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      wcnt_q       <= '0;
      csum_q       <= '0;
      lo_q         <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ERR_NONE;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      wcnt_q       <= wcnt_d;
      csum_q       <= csum_d;
      lo_q         <= lo_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign done       = done_q;
  assign err_code   = err_q;
  assign run_cycles = run_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_stack_prog_loader: directed frame vectors plus timing sequences for the loader.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_stack_prog_loader;

  localparam int M_HALT  = 0;
  localparam int M_FAULT = 1;
  localparam int M_NEVER = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [11:0] imem_wdata;
  logic        core_rst_n;
  logic        core_guard;
  logic        core_value;
  logic        done;
  logic [1:0]  err_code;
  logic [15:0] run_cycles;

  always #5 clk = ~clk;

  stack_prog_loader #(
    .ADDR_W (8),
    .INSTR_W(12),
    .MAX_RUN(16'd10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n),
    .core_guard(core_guard),
    .core_value(core_value),
    .done      (done),
    .err_code  (err_code),
    .run_cycles(run_cycles)
  );

  // Core model: behaviour keyed to the 1-based cycle count since release.
  int core_mode = M_NEVER;
  int core_k    = 0;
  int run_cnt   = 0;

  always @(posedge clk) begin
    if (!core_rst_n) run_cnt <= 0;
    else             run_cnt <= run_cnt + 1;
  end

  always_comb begin
    core_guard = 1'b1;
    core_value = 1'b0;
    if (core_rst_n) begin
      if (core_mode == M_HALT  && run_cnt + 1 == core_k) core_value = 1'b1;
      if (core_mode == M_FAULT && run_cnt + 1 == core_k) core_guard = 1'b0;
    end
  end

  logic [11:0] mem [256];
  int wr_total  = 0;
  int rel_total = 0;

  always @(negedge clk) begin
    if (imem_we) begin
      mem[imem_addr] <= imem_wdata;
      wr_total       <= wr_total + 1;
    end
    if (core_rst_n) rel_total <= rel_total + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge; the rising edge in between carries the transfer.
  task automatic send_byte(input logic [7:0] b);
    int w;
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("send_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_end(output int wc);
    wc = 0;
    while (!(done || err_code != 2'd0) && wc < 1000) begin
      @(negedge clk);
      wc++;
    end
    check("end_reached", 32'(wc < 1000), 32'd1);
  endtask

  typedef struct packed {
    int              n;
    logic [3:0][11:0] ins;
    int              csum_off;
    bit              bad_hi;
    int              mode;
    int              k;
    int              exp_err;
    bit              exp_done;
    int              exp_run;
    int              exp_wr;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [11:0] i0, i1, i2, i3,
                              input int csum_off, input bit bad_hi, input int mode, input int k,
                              input int exp_err, input bit exp_done, input int exp_run,
                              input int exp_wr);
    vec_t v;
    v.n        = n;
    v.ins      = {i3, i2, i1, i0};
    v.csum_off = csum_off;
    v.bad_hi   = bad_hi;
    v.mode     = mode;
    v.k        = k;
    v.exp_err  = exp_err;
    v.exp_done = exp_done;
    v.exp_run  = exp_run;
    v.exp_wr   = exp_wr;
    return v;
  endfunction

  task automatic send_frame(input vec_t v);
    logic [7:0]  cs;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [11:0] w;
    send_byte(8'hA5);
    send_byte(v.n[7:0]);
    if (v.n == 0) return;
    cs = v.n[7:0];
    for (int i = 0; i < v.n; i++) begin
      w  = v.ins[i];
      lo = w[7:0];
      hi = (v.bad_hi && i == 0) ? 8'h10 : {4'h0, w[11:8]};
      send_byte(lo);
      send_byte(hi);
      if (v.bad_hi) return;
      cs = cs + lo + hi;
    end
    send_byte(cs + v.csum_off[7:0]);
  endtask

  vec_t vecs [8];

  initial begin
    int wc;
    int wr_snap;
    int rel_snap;
    int fc;

    vecs[0] = mk(2, 12'h00A, 12'h00B, 12'h000, 12'h000, 0, 1'b0, M_HALT,  2,  0, 1'b1, 2,  256);
    vecs[1] = mk(2, 12'h00A, 12'h00B, 12'h000, 12'h000, 1, 1'b0, M_HALT,  2,  2, 1'b0, 0,  2);
    vecs[2] = mk(0, 12'h000, 12'h000, 12'h000, 12'h000, 0, 1'b0, M_NEVER, 0,  1, 1'b0, 0,  0);
    vecs[3] = mk(1, 12'h000, 12'h000, 12'h000, 12'h000, 0, 1'b1, M_NEVER, 0,  1, 1'b0, 0,  0);
    vecs[4] = mk(3, 12'h123, 12'h456, 12'h789, 12'h000, 0, 1'b0, M_FAULT, 5,  3, 1'b0, 5,  256);
    vecs[5] = mk(1, 12'h0FF, 12'h000, 12'h000, 12'h000, 0, 1'b0, M_NEVER, 0,  3, 1'b0, 10, 256);
    vecs[6] = mk(1, 12'h001, 12'h000, 12'h000, 12'h000, 0, 1'b0, M_HALT,  10, 0, 1'b1, 10, 256);
    vecs[7] = mk(4, 12'h111, 12'h222, 12'h333, 12'hB00, 0, 1'b0, M_HALT,  1,  0, 1'b1, 1,  256);

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset values and first ready cycle.
    repeat (3) @(negedge clk);
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_imem_we",    32'(imem_we),    32'd0);
    check("rst_imem_addr",  32'(imem_addr),  32'd0);
    check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_err_code",   32'(err_code),   32'd0);
    check("rst_run_cycles", 32'(run_cycles), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Stray bytes in IDLE, then a hand-timed N=2 load.
    wr_snap = wr_total;
    send_byte(8'h00);
    send_byte(8'h5A);
    send_byte(8'hFF);
    check("stray_err",    32'(err_code),          32'd0);
    check("stray_writes", 32'(wr_total - wr_snap), 32'd0);

    core_mode = M_HALT;
    core_k    = 2;
    wr_snap   = wr_total;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h0A);
    check("lo_no_write", 32'(imem_we), 32'd0);
    send_byte(8'h00);
    check("hi0_we",    32'(imem_we),    32'd1);
    check("hi0_addr",  32'(imem_addr),  32'd0);
    check("hi0_wdata", 32'(imem_wdata), 32'h00A);
    send_byte(8'h0B);
    send_byte(8'h00);
    check("hi1_we",    32'(imem_we),    32'd1);
    check("hi1_addr",  32'(imem_addr),  32'd1);
    check("hi1_wdata", 32'(imem_wdata), 32'h00B);
    send_byte(8'h17);
    check("fill0_we",    32'(imem_we),    32'd1);
    check("fill0_addr",  32'(imem_addr),  32'd2);
    check("fill0_wdata", 32'(imem_wdata), 32'h00B);
    check("fill_ready",  32'(in_ready),   32'd0);
    fc = 0;
    while (!(imem_we && imem_addr == 8'hFF) && fc < 400) begin
      @(negedge clk);
      fc++;
    end
    check("fill_last_seen", 32'(fc < 400), 32'd1);
    check("fill_last_core", 32'(core_rst_n), 32'd0);
    @(negedge clk);
    check("run_release", 32'(core_rst_n), 32'd1);
    check("run_no_we",   32'(imem_we),    32'd0);
    wait_end(wc);
    @(negedge clk);
    check("h_done",    32'(done),                32'd1);
    check("h_err",     32'(err_code),            32'd0);
    check("h_run",     32'(run_cycles),          32'd2);
    check("h_writes",  32'(wr_total - wr_snap),  32'd256);
    check("h_mem0",    32'(mem[0]),              32'h00A);
    check("h_mem1",    32'(mem[1]),              32'h00B);
    check("h_mem2",    32'(mem[2]),              32'h00B);
    check("h_mem255",  32'(mem[255]),            32'h00B);

    // Table of complete frames.
    for (int i = 0; i < 8; i++) begin
      core_mode = vecs[i].mode;
      core_k    = vecs[i].k;
      wr_snap   = wr_total;
      rel_snap  = rel_total;
      send_frame(vecs[i]);
      wait_end(wc);
      if (vecs[i].exp_err == 1 || vecs[i].exp_err == 2)
        check($sformatf("v%0d_err_latency", i), 32'(wc), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_err", i),      32'(err_code),             32'(vecs[i].exp_err));
      check($sformatf("v%0d_done", i),     32'(done),                 32'(vecs[i].exp_done));
      check($sformatf("v%0d_run", i),      32'(run_cycles),           32'(vecs[i].exp_run));
      check($sformatf("v%0d_writes", i),   32'(wr_total - wr_snap),   32'(vecs[i].exp_wr));
      check($sformatf("v%0d_released", i), 32'(rel_total - rel_snap), 32'(vecs[i].exp_run));
      check($sformatf("v%0d_core_rst", i), 32'(core_rst_n),           32'd0);
      check($sformatf("v%0d_ready", i),    32'(in_ready),             32'd1);
    end
    check("v7_mem3", 32'(mem[3]), 32'hB00);
    check("v7_mem4", 32'(mem[4]), 32'h00B);

    // Reset pulse mid-frame, stray bytes, then a clean reload.
    core_mode = M_HALT;
    core_k    = 3;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h0A);
    send_byte(8'h00);
    send_byte(8'h0B);
    rst_n = 1'b0;
    @(negedge clk);
    check("pulse_ready",    32'(in_ready),   32'd0);
    check("pulse_core_rst", 32'(core_rst_n), 32'd0);
    check("pulse_we",       32'(imem_we),    32'd0);
    check("pulse_done",     32'(done),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("pulse_ready_back", 32'(in_ready), 32'd1);
    wr_snap = wr_total;
    send_byte(8'h33);
    send_byte(8'h02);
    check("pulse_stray_writes", 32'(wr_total - wr_snap), 32'd0);
    check("pulse_stray_err",    32'(err_code),           32'd0);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hC1);
    send_byte(8'h03);
    send_byte(8'h0B);
    send_byte(8'h00);
    send_byte(8'hD1);
    wait_end(wc);
    @(negedge clk);
    check("reload_done", 32'(done),       32'd1);
    check("reload_err",  32'(err_code),   32'd0);
    check("reload_run",  32'(run_cycles), 32'd3);
    check("reload_mem0", 32'(mem[0]),     32'h3C1);
    check("reload_mem1", 32'(mem[1]),     32'h00B);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
